// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bundles the fetch stage's memory-port, decode-handshake and
//               branch-redirect signals. The master modport is the fetch
//               stage; the slave modport is its environment (memory, decode
//               and execute seen together).
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
    // Instruction memory port
    logic [31:0] instruction_address;
    logic [31:0] instruction;
    // Instruction register handed to decode
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    // Redirect request from execute
    logic        branch_taken;
    logic [31:0] branch_target;

    modport master (
        output instruction_address,
        input  instruction,
        output ir_out,
        output ir_pc,
        output ir_valid,
        input  ir_ready,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  instruction_address,
        output instruction,
        input  ir_out,
        input  ir_pc,
        input  ir_valid,
        output ir_ready,
        output branch_taken,
        output branch_target
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage. Holds the PC, captures one word plus its PC into
//               a 1-deep instruction register offered to decode via
//               valid/ready, and handles branch redirect/flush, halt-opcode
//               detection and sticky invalid-fetch detection.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] TEXT_BASE    = 32'd2097152,
    parameter logic [5:0]  HALT_OPCODE  = 6'b111110,
    parameter logic [31:0] INVALID_WORD = 32'hFFFFFFFF
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           en,
    instruction_fetch_if.master bus,
    output logic                halted,
    output logic                fetch_error
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir_out;
    logic [31:0] r_ir_pc;
    logic        r_ir_valid;
    logic        r_fetch_error;

    logic        w_consume;
    logic        w_load;

    // Decode takes the IR this edge; a new word may be loaded when the IR is
    // empty or being drained on the same edge.
    assign w_consume = r_ir_valid & bus.ir_ready;
    assign w_load    = en & (r_state == ST_RUN) & (~r_ir_valid | bus.ir_ready);

    // Memory is addressed straight from the PC register.
    assign bus.instruction_address = r_pc;
    assign bus.ir_out              = r_ir_out;
    assign bus.ir_pc               = r_ir_pc;
    assign bus.ir_valid            = r_ir_valid;
    assign fetch_error             = r_fetch_error;

    // Halted only once the halt word itself has been handed to decode.
    assign halted = (r_state == ST_HALT) & ~r_ir_valid;

    // PC, instruction register and fetch FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= TEXT_BASE;
            r_ir_out      <= 32'd0;
            r_ir_pc       <= 32'd0;
            r_ir_valid    <= 1'b0;
            r_fetch_error <= 1'b0;
        end else begin
            // Consumption drains the IR in every state, even with en low;
            // a load on the same edge overrides this below.
            if (w_consume) begin
                r_ir_valid <= 1'b0;
            end
            if (en) begin
                case (r_state)
                    ST_BOOT: begin
                        // One dead cycle so memory leaves its reset output.
                        r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (bus.branch_taken) begin
                            // Redirect flushes the IR even if not yet consumed.
                            r_ir_valid <= 1'b0;
                            if (bus.branch_target < TEXT_BASE) begin
                                r_fetch_error <= 1'b1;
                                r_state       <= ST_ERROR;
                            end else begin
                                r_pc <= bus.branch_target;
                            end
                        end else if (w_load) begin
                            if (bus.instruction == INVALID_WORD) begin
                                r_fetch_error <= 1'b1;
                                r_state       <= ST_ERROR;
                            end else begin
                                r_ir_out   <= bus.instruction;
                                r_ir_pc    <= r_pc;
                                r_ir_valid <= 1'b1;
                                if (bus.instruction[31:26] == HALT_OPCODE) begin
                                    r_state <= ST_HALT;
                                end else begin
                                    // Wrap to 0 lands outside text and is
                                    // caught as an invalid fetch next time.
                                    r_pc <= r_pc + 32'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        // HALT and ERROR leave only through reset.
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch. A small
//               word array stands in for the text segment; anything outside
//               it, or any read during reset, returns the invalid word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam logic [31:0] c_tb   = 32'd2097152;
    localparam logic [31:0] c_inv  = 32'hFFFFFFFF;
    localparam logic [31:0] c_halt = 32'hF8000000;

    logic clk;
    logic reset;
    logic en;
    logic halted;
    logic fetch_error;

    int total;
    int passed;

    logic [31:0] mem [0:63];

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .bus         (bus.master),
        .halted      (halted),
        .fetch_error (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] addr, input logic rst_in);
        logic [31:0] idx;
        idx = addr - c_tb;
        if (rst_in || addr < c_tb || idx > 32'd63)
            return c_inv;
        return mem[idx[5:0]];
    endfunction

    // Present the word at the current PC, then advance one clock edge and
    // settle for sampling.
    task automatic cyc();
        bus.instruction = mem_rd(bus.instruction_address, reset);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        for (int i = 0; i < 64; i++) mem[i] = c_inv;
        mem[0]  = 32'h11111111;
        mem[1]  = 32'h22222222;
        mem[2]  = 32'h33333333;
        mem[3]  = 32'h44444444;
        mem[4]  = 32'h55555555;
        mem[5]  = c_halt;
        mem[48] = 32'h66666666;
        mem[49] = 32'h77777777;
        mem[62] = 32'h12345678;

        en                = 1'b1;
        bus.ir_ready      = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.instruction   = c_inv;
        reset             = 1'b1;
        #2;
        chk("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("rst_addr", bus.instruction_address, c_tb);
        chk("rst_ir_out", bus.ir_out, 32'd0);
        chk("rst_ir_pc", bus.ir_pc, 32'd0);
        chk("rst_err", {31'd0, fetch_error}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming: BOOT cycle, then A, B, C back to back
        cyc();
        chk("boot_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("boot_pc", bus.instruction_address, c_tb);
        cyc();
        chk("a_out", bus.ir_out, 32'h11111111);
        chk("a_pc", bus.ir_pc, c_tb);
        chk("a_valid", {31'd0, bus.ir_valid}, 32'd1);
        cyc();
        chk("b_out", bus.ir_out, 32'h22222222);
        chk("b_pc", bus.ir_pc, c_tb + 32'd1);
        chk("b_valid", {31'd0, bus.ir_valid}, 32'd1);
        cyc();
        chk("c_out", bus.ir_out, 32'h33333333);
        chk("c_pc", bus.ir_pc, c_tb + 32'd2);
        chk("c_next_pc", bus.instruction_address, c_tb + 32'd3);

        // Stall three cycles with C held, then D replaces it on release
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_out", bus.ir_out, 32'h33333333);
            chk("stall_pc", bus.instruction_address, c_tb + 32'd3);
            chk("stall_valid", {31'd0, bus.ir_valid}, 32'd1);
        end
        bus.ir_ready = 1'b1;
        cyc();
        chk("d_out", bus.ir_out, 32'h44444444);
        chk("d_pc", bus.ir_pc, c_tb + 32'd3);
        chk("d_next_pc", bus.instruction_address, c_tb + 32'd4);

        // Branch while D is unconsumed: flush and redirect
        bus.ir_ready      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = c_tb + 32'd48;
        cyc();
        chk("br_flush", {31'd0, bus.ir_valid}, 32'd0);
        chk("br_pc", bus.instruction_address, c_tb + 32'd48);
        bus.branch_taken = 1'b0;
        bus.ir_ready     = 1'b1;
        cyc();
        chk("br_ir_pc", bus.ir_pc, c_tb + 32'd48);
        chk("br_ir_out", bus.ir_out, 32'h66666666);
        chk("br_valid", {31'd0, bus.ir_valid}, 32'd1);

        // Halt word at TEXT_BASE+5
        bus.branch_taken  = 1'b1;
        bus.branch_target = c_tb + 32'd4;
        cyc();
        bus.branch_taken = 1'b0;
        cyc();
        chk("pre_halt_out", bus.ir_out, 32'h55555555);
        cyc();
        chk("halt_out", bus.ir_out, c_halt);
        chk("halt_ir_pc", bus.ir_pc, c_tb + 32'd5);
        chk("halt_pc", bus.instruction_address, c_tb + 32'd5);
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        bus.ir_ready = 1'b0;
        cyc();
        chk("halt_offered", {31'd0, bus.ir_valid}, 32'd1);
        chk("halt_held_pc", bus.instruction_address, c_tb + 32'd5);
        bus.ir_ready = 1'b1;
        cyc();
        chk("halted", {31'd0, halted}, 32'd1);
        chk("halt_drained", {31'd0, bus.ir_valid}, 32'd0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = c_tb + 32'd48;
        cyc();
        chk("halt_br_ign", bus.instruction_address, c_tb + 32'd5);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        bus.branch_taken = 1'b0;

        // Redirect below TEXT_BASE
        do_reset();
        cyc();
        cyc();
        chk("r2_a_valid", {31'd0, bus.ir_valid}, 32'd1);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'd100;
        cyc();
        chk("bad_br_err", {31'd0, fetch_error}, 32'd1);
        chk("bad_br_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("bad_br_pc", bus.instruction_address, c_tb + 32'd1);
        bus.branch_taken = 1'b0;
        cyc();
        chk("err_sticky", {31'd0, fetch_error}, 32'd1);
        chk("err_no_cap", {31'd0, bus.ir_valid}, 32'd0);
        chk("err_halted", {31'd0, halted}, 32'd0);

        // Sequential fetch of the invalid word
        do_reset();
        cyc();
        chk("r3_err_clr", {31'd0, fetch_error}, 32'd0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = c_tb + 32'd62;
        cyc();
        bus.branch_taken = 1'b0;
        cyc();
        chk("pre_inv_out", bus.ir_out, 32'h12345678);
        chk("pre_inv_valid", {31'd0, bus.ir_valid}, 32'd1);
        cyc();
        chk("inv_err", {31'd0, fetch_error}, 32'd1);
        chk("inv_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("inv_pc", bus.instruction_address, c_tb + 32'd63);
        chk("inv_ir_out", bus.ir_out, 32'h12345678);
        cyc();
        chk("inv_sticky", {31'd0, fetch_error}, 32'd1);

        // Enable low freezes PC and ignores branches; consume still drains
        do_reset();
        cyc();
        cyc();
        chk("r4_a_out", bus.ir_out, 32'h11111111);
        en                = 1'b0;
        bus.ir_ready      = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = c_tb + 32'd48;
        cyc();
        chk("en0_pc", bus.instruction_address, c_tb + 32'd1);
        chk("en0_valid", {31'd0, bus.ir_valid}, 32'd1);
        chk("en0_out", bus.ir_out, 32'h11111111);
        bus.branch_taken = 1'b0;
        bus.ir_ready     = 1'b1;
        cyc();
        chk("en0_consume", {31'd0, bus.ir_valid}, 32'd0);
        chk("en0_pc2", bus.instruction_address, c_tb + 32'd1);
        en = 1'b1;
        cyc();
        chk("en1_b_out", bus.ir_out, 32'h22222222);
        chk("en1_b_valid", {31'd0, bus.ir_valid}, 32'd1);

        // Asynchronous reset mid-run, checked before any clock edge
        #1;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("async_addr", bus.instruction_address, c_tb);
        chk("async_err", {31'd0, fetch_error}, 32'd0);
        chk("async_ir_out", bus.ir_out, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the unified memory's instruction port; drives `instruction_address` and consumes the combinational `instruction` word.
- Keeps the program counter, registers one fetched word plus its PC into a 1-deep instruction register, and hands it to decode with a valid/ready handshake.
- Handles branch redirect/flush, halt-opcode detection and invalid-fetch detection (memory returns 32'hFFFFFFFF below the text base or during reset).

Parameters:
TEXT_BASE, 32'd2097152, word address of the first instruction (n/2 of memory); PC reset value
HALT_OPCODE, 6'b111110, opcode in instruction[31:26] that ends fetching
INVALID_WORD, 32'hFFFFFFFF, word the memory returns for a non-text or reset fetch

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
en  input  1  fetch enable; low freezes PC and FSM
instruction  input  32  word from memory at instruction_address, valid same cycle (combinational)
instruction_address  output  32  current PC, driven straight from the PC register
ir_out  output  32  registered instruction to decode
ir_pc  output  32  PC of ir_out
ir_valid  output  1  ir_out holds an unconsumed instruction
ir_ready  input  1  decode accepts ir_out this cycle when ir_valid=1
branch_taken  input  1  redirect request from execute
branch_target  input  32  word address of redirect
halted  output  1  FSM in HALT and IR drained
fetch_error  output  1  sticky invalid-fetch / bad-redirect flag

Behaviour:
- Reset, asynchronous: pc=TEXT_BASE, ir_out=0, ir_pc=0, ir_valid=0, fetch_error=0, state=BOOT; so halted=0.
- FSM states: BOOT, RUN, HALT, ERROR.
  - BOOT lasts exactly one cycle after reset deassert with no capture, then moves to RUN.
  - HALT and ERROR exit only through reset.
- Definitions:
  - consume = ir_valid & ir_ready.
  - load = en & state==RUN & (~ir_valid | ir_ready).
- Consume clears ir_valid in any state, including en=0, unless the same edge loads a new word.
- RUN, priority order, evaluated only when en=1:
  1. branch_taken, regardless of load:
     - ir_valid<=0 (flush, even if unconsumed); no capture.
     - If branch_target<TEXT_BASE: fetch_error<=1, state<=ERROR.
     - Otherwise pc<=branch_target.
  2. load and instruction==INVALID_WORD:
     - No capture; ir_valid<=0 on consume.
     - fetch_error<=1, state<=ERROR, pc unchanged.
  3. load and instruction[31:26]==HALT_OPCODE:
     - ir_out<=instruction, ir_pc<=pc, ir_valid<=1.
     - pc unchanged, state<=HALT.
  4. load otherwise:
     - ir_out<=instruction, ir_pc<=pc, ir_valid<=1.
     - pc<=pc+1, 32-bit modulo. Wrap to 0 yields INVALID_WORD next fetch, which is then case 2.
  5. No load (stall): pc, ir_out, ir_pc held.
- Throughput and latency:
  - With ir_ready held high, one instruction per cycle.
  - Latency from pc to ir_valid is 1 cycle.
- HALT/ERROR: branch_taken ignored; no captures; the pending IR (halt word) is still offered until consumed.
- halted = (state==HALT) & ~ir_valid, combinational from registers.
- en=0: pc, state, ir_out, ir_pc, fetch_error frozen; branch_taken ignored (execute must hold it).

Test Plan:
1. Reset then run, ir_ready=1, mem[TEXT_BASE..+2]=A,B,C.
   -> BOOT cycle with ir_valid=0.
   -> Next three edges give ir_out=A/B/C with ir_pc=2097152/2097153/2097154.
   -> ir_valid=1 continuous.
2. Stall: ir_ready=0 for 3 cycles after A is captured.
   -> ir_out=A and pc=2097153 held.
   -> On ir_ready=1, B is captured on the same edge A is consumed.
3. Branch while IR full and unconsumed, branch_target=2097200.
   -> Next edge ir_valid=0, pc=2097200.
   -> Following edge ir_pc=2097200.
4. Halt word 32'hF8000000 at TEXT_BASE+5.
   -> Captured with ir_pc=2097157, pc stays 2097157.
   -> halted=1 the cycle after consumption; later branch_taken ignored.
5. Branch to target 100 (below TEXT_BASE), and separately sequential fetch of 32'hFFFFFFFF.
   -> fetch_error=1, ir_valid=0, state sticks until reset.
6. Assert reset mid-run with ir_valid=1.
   -> Immediately, without a clock edge: ir_valid=0, instruction_address=2097152, fetch_error=0.
